// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light slice: detector state encoding,
// detector defaults and controller timing constants.
package tl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL_ON  = 2'd1,
        PRESENT  = 2'd2,
        QUAL_OFF = 2'd3
    } tl_vd_state_e;

    localparam int TL_DEB_CYCLES   = 16;
    localparam int TL_HOLD_CYCLES  = 64;
    localparam int TL_CNT_W        = 8;
    localparam int TL_STUCK_CYCLES = 4096;

    // Controller timing, kept here so detector and controller agree.
    localparam int TL_HWY_GREEN_MIN  = 1024;
    localparam int TL_FARM_GREEN_MAX = 512;
    localparam int TL_YELLOW_CYCLES  = 128;

    // Counter width able to hold values 0..max_val.
    function automatic int tl_cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tl_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs, per-bit, with
// asynchronous active-low reset.
module tl_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/tl_vehicle_detect.sv
// Farm-road loop conditioner: synchronise, debounce, minimum hold, arrival count.
// Optional stuck-loop fault detection is built when TL_VD_STUCK_DETECT_EN is defined.
module tl_vehicle_detect
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES  = TL_DEB_CYCLES,
    parameter int HOLD_CYCLES = TL_HOLD_CYCLES,
`ifdef TL_VD_STUCK_DETECT_EN
    parameter int STUCK_CYCLES = TL_STUCK_CYCLES,
`endif
    parameter int CNT_W       = TL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loop_raw,
    input  logic             clr_cnt,
    output logic             car_present,
    output logic             arrive_pulse,
    output logic [CNT_W-1:0] car_cnt,
    output logic             stuck_flt
);

    localparam int DEB_W  = tl_cnt_width(DEB_CYCLES);
    localparam int HOLD_W = tl_cnt_width(HOLD_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic sy;

    tl_sync2 #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (loop_raw),
        .q   (sy)
    );

    tl_vd_state_e      state_reg, state_next;
    logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next, hold_inc;
    logic [CNT_W-1:0]  car_cnt_reg, car_cnt_next;
    logic              car_present_reg, car_present_next;
    logic              arrive_pulse_reg;
    logic              arrive;
    logic              stuck_flt_next;

    assign hold_inc = (hold_cnt_reg == HOLD_MAX) ? HOLD_MAX : hold_cnt_reg + HOLD_W'(1);

    always_comb begin
        state_next    = state_reg;
        deb_cnt_next  = deb_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        arrive        = 1'b0;
        case (state_reg)
            IDLE: begin
                deb_cnt_next = '0;
                if (sy) begin
                    state_next   = QUAL_ON;
                    deb_cnt_next = DEB_W'(1);
                end
            end
            QUAL_ON: begin
                if (!sy) begin
                    state_next   = IDLE;
                    deb_cnt_next = '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    state_next    = PRESENT;
                    deb_cnt_next  = '0;
                    hold_cnt_next = '0;
                    arrive        = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt_reg + DEB_W'(1);
                end
            end
            PRESENT: begin
                hold_cnt_next = hold_inc;
                if (!sy) begin
                    state_next   = QUAL_OFF;
                    deb_cnt_next = DEB_W'(1);
                end
            end
            QUAL_OFF: begin
                hold_cnt_next = hold_inc;
                if (sy) begin
                    // Dropout recovered: same vehicle, hold keeps running.
                    state_next   = PRESENT;
                    deb_cnt_next = '0;
                end else begin
                    deb_cnt_next = (deb_cnt_reg == DEB_MAX) ? DEB_MAX : deb_cnt_reg + DEB_W'(1);
                    if (deb_cnt_next == DEB_MAX && hold_cnt_next == HOLD_MAX) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                deb_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        car_cnt_next = car_cnt_reg;
        if (arrive) begin
            if (clr_cnt) begin
                car_cnt_next = CNT_W'(1);
            end else if (car_cnt_reg != {CNT_W{1'b1}}) begin
                car_cnt_next = car_cnt_reg + CNT_W'(1);
            end
        end else if (clr_cnt) begin
            car_cnt_next = '0;
        end
    end

`ifdef TL_VD_STUCK_DETECT_EN
    localparam int STK_W = tl_cnt_width(STUCK_CYCLES);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYCLES);

    logic [STK_W-1:0] stuck_cnt_reg, stuck_cnt_next;
    logic             stuck_flt_reg;

    always_comb begin
        stuck_cnt_next = '0;
        if (state_reg == PRESENT || state_reg == QUAL_OFF) begin
            stuck_cnt_next = (stuck_cnt_reg == STK_MAX) ? STK_MAX : stuck_cnt_reg + STK_W'(1);
        end
        stuck_flt_next = stuck_flt_reg | (stuck_cnt_next == STK_MAX);
        if (state_next == IDLE) begin
            stuck_flt_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stuck_cnt_reg <= '0;
            stuck_flt_reg <= 1'b0;
        end else begin
            stuck_cnt_reg <= stuck_cnt_next;
            stuck_flt_reg <= stuck_flt_next;
        end
    end

    assign stuck_flt = stuck_flt_reg;
`else
    assign stuck_flt_next = 1'b0;
    assign stuck_flt      = 1'b0;
`endif

    // A raised fault keeps the farm road served regardless of the FSM.
    assign car_present_next = (state_next == PRESENT) || (state_next == QUAL_OFF) || stuck_flt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            deb_cnt_reg      <= '0;
            hold_cnt_reg     <= '0;
            car_cnt_reg      <= '0;
            car_present_reg  <= 1'b0;
            arrive_pulse_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            deb_cnt_reg      <= deb_cnt_next;
            hold_cnt_reg     <= hold_cnt_next;
            car_cnt_reg      <= car_cnt_next;
            car_present_reg  <= car_present_next;
            arrive_pulse_reg <= arrive;
        end
    end

    assign car_present  = car_present_reg;
    assign arrive_pulse = arrive_pulse_reg;
    assign car_cnt      = car_cnt_reg;

endmodule

// File: tb/tb_tl_vehicle_detect.sv
// Bench for tl_vehicle_detect: directed scenarios plus random loop activity,
// every cycle compared against a run-length reference model.
`timescale 1ns/1ps
module tb_tl_vehicle_detect;

    localparam int DEB   = 4;
    localparam int HOLD  = 10;
    localparam int CW    = 3;
    localparam int STUCK = 50;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef TL_VD_STUCK_DETECT_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          loop_raw = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          car_present;
    logic          arrive_pulse;
    logic [CW-1:0] car_cnt;
    logic          stuck_flt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tl_vehicle_detect #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD),
`ifdef TL_VD_STUCK_DETECT_EN
        .STUCK_CYCLES(STUCK),
`endif
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .loop_raw    (loop_raw),
        .clr_cnt     (clr_cnt),
        .car_present (car_present),
        .arrive_pulse(arrive_pulse),
        .car_cnt     (car_cnt),
        .stuck_flt   (stuck_flt)
    );

    // Reference model: presence rises after DEB consecutive synchronised highs,
    // falls after DEB consecutive lows once HOLD cycles have passed since rising.
    bit m_s1, m_sy, m_pres, m_arrive, m_stuck;
    int m_run1, m_run0, m_cnt, m_edge, m_rise, n_arrivals;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_sy = 0; m_pres = 0; m_arrive = 0; m_stuck = 0;
        m_run1 = 0; m_run0 = 0; m_cnt = 0; m_edge = 0; m_rise = 0;
    endtask

    task automatic model_edge();
        bit sample;
        if (!rst) begin
            model_reset();
        end else begin
            sample = m_sy;
            m_sy   = m_s1;
            m_s1   = loop_raw;
            m_edge++;
            if (sample) begin m_run1++; m_run0 = 0; end
            else        begin m_run0++; m_run1 = 0; end
            m_arrive = 0;
            if (!m_pres && m_run1 >= DEB) begin
                m_pres   = 1;
                m_rise   = m_edge;
                m_arrive = 1;
                m_cnt    = clr_cnt ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : m_cnt);
            end else begin
                if (m_pres && m_run0 >= DEB && (m_edge - m_rise) >= HOLD) m_pres = 0;
                if (clr_cnt) m_cnt = 0;
            end
            m_stuck = STUCK_EN && m_pres && ((m_edge - m_rise) >= STUCK);
        end
    endtask

    task automatic compare_all();
        check("car_present", car_present, m_pres);
        check("arrive_pulse", arrive_pulse, m_arrive);
        check("car_cnt", car_cnt, m_cnt);
        check("stuck_flt", stuck_flt, m_stuck);
    endtask

    task automatic step(input logic lr, input logic clr);
        @(negedge clk);
        loop_raw = lr;
        clr_cnt  = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (arrive_pulse) begin
            n_arrivals++;
            $display("arrival %0d car_cnt=%0d at %0t", n_arrivals, car_cnt, $time);
        end
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        int lat, cyc, start_arr;
        bit seen;
        logic lvl;
        int len;

        model_reset();
        n_arrivals = 0;
        #1;
        compare_all();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        check("idle_cnt", car_cnt, 0);

        // Rise and fall latency with a stable input.
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0);
            if (car_present && lat == 0) lat = i;
        end
        check("rise_lat", lat, DEB + 2);
        check("first_cnt", car_cnt, 1);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0);
            if (!car_present && lat == 0) lat = i;
        end
        check("fall_lat", lat, DEB + 2);

        // Short pulse must not assert.
        seen = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            if (car_present) seen = 1;
        end
        check("glitch_on", seen, 0);

        // Short dropout must not deassert or add an arrival.
        start_arr = n_arrivals;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0);
            if (!car_present) seen = 1;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (!car_present) seen = 1;
        end
        check("dropout_hold", seen, 0);
        check("dropout_arrivals", n_arrivals - start_arr, 1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

        // Minimum hold after a brief presence.
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            if (car_present) cyc++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            if (car_present) cyc++;
        end
        check("hold_cycles", cyc, HOLD);

        // Saturation of the arrival counter.
        step(1'b0, 1'b1);
        check("clr_only", car_cnt, 0);
        start_arr = n_arrivals;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
            for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        end
        check("sat_cnt", car_cnt, CMAX);
        check("sat_arrivals", n_arrivals - start_arr, 9);

        // Clear coinciding with an arrival.
        for (int i = 0; i < DEB + 1; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("clr_arrive_pulse", arrive_pulse, 1);
        check("clr_arrive_cnt", car_cnt, 1);

        // Reset while debouncing the falling edge.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("qual_off_present", car_present, 1);
        async_reset();
        check("rst_present", car_present, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Long presence: fault flag when built in, otherwise stays 0.
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
        check("stuck_set", stuck_flt, STUCK_EN);
        check("stuck_present", car_present, 1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        check("stuck_clear", stuck_flt, 0);
        check("stuck_idle", car_present, 0);

        // Random runs of loop activity with sporadic clears and resets.
        lvl = 1'b0;
        for (int r = 0; r < 200; r++) begin
            lvl = ~lvl;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 3 * DEB);
            for (int i = 0; i < len; i++) step(lvl, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 40) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
